// File: rtl/pps_task_scheduler.sv
// Per-second task scheduler: programmable per-channel periods counted on PPS, one shared req/ack consumer port.
// Optional PPS_SCHED_FIXED_PRIO_EN selects lowest-index-first arbitration instead of round-robin.
module pps_task_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 2,
  parameter int PERIOD_W = 16
) (
  input  logic                clk_50m,
  input  logic                reset_n,
  input  logic                pps,
  input  logic [NUM_CH-1:0]   ch_enable,
  input  logic                period_wr,
  input  logic [CH_W-1:0]     period_ch,
  input  logic [PERIOD_W-1:0] period_data,
  output logic                task_req,
  output logic [CH_W-1:0]     task_id,
  input  logic                task_ack,
  output logic [NUM_CH-1:0]   pending,
  output logic [NUM_CH-1:0]   overrun,
  input  logic                overrun_clr
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t              state_r;
  logic                task_req_r;
  logic [CH_W-1:0]     task_id_r;
  logic [NUM_CH-1:0]   pending_r;
  logic [NUM_CH-1:0]   overrun_r;
  logic [PERIOD_W-1:0] cnt_r    [NUM_CH];
  logic [PERIOD_W-1:0] period_r [NUM_CH];

  logic [NUM_CH-1:0]   ack_vec_s;
  logic [NUM_CH-1:0]   wr_hit_s;
  logic [NUM_CH-1:0]   fire_s;
  logic [NUM_CH-1:0]   overrun_set_s;
  logic [CH_W-1:0]     winner_s;
  logic                found_s;

  // Compare at PERIOD_W+1 bits so an all-ones period never wraps; period 0 behaves as 1.
  function automatic logic period_reached(input logic [PERIOD_W-1:0] cnt,
                                          input logic [PERIOD_W-1:0] period);
    logic [PERIOD_W:0] eff;
    eff = (period == {PERIOD_W{1'b0}}) ? {{PERIOD_W{1'b0}}, 1'b1} : {1'b0, period};
    return ({1'b0, cnt} + {{PERIOD_W{1'b0}}, 1'b1}) >= eff;
  endfunction

  // Per-channel fire, ack and overrun decode for this cycle.
  always_comb begin
    ack_vec_s     = {NUM_CH{1'b0}};
    wr_hit_s      = {NUM_CH{1'b0}};
    fire_s        = {NUM_CH{1'b0}};
    overrun_set_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      ack_vec_s[i]     = (state_r == ST_REQ) && task_ack && (task_id_r == CH_W'(i));
      wr_hit_s[i]      = period_wr && (period_ch == CH_W'(i));
      fire_s[i]        = pps && ch_enable[i] && !wr_hit_s[i] && period_reached(cnt_r[i], period_r[i]);
      overrun_set_s[i] = fire_s[i] && pending_r[i] && !ack_vec_s[i];
    end
  end

`ifdef PPS_SCHED_FIXED_PRIO_EN
  // Fixed priority: descending scan so the lowest pending index is written last.
  always_comb begin
    winner_s = {CH_W{1'b0}};
    found_s  = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      winner_s = pending_r[k] ? CH_W'(k) : winner_s;
      found_s  = found_s | pending_r[k];
    end
  end
`else
  logic [CH_W-1:0]     last_r;
  logic [2*NUM_CH-1:0] rot_full_s;
  logic [NUM_CH-1:0]   rot_s;
  logic [CH_W:0]       off_s;
  logic [CH_W:0]       sum_s;

  // Round-robin: rotate pending so bit 0 is last+1, take the lowest set offset, map back modulo NUM_CH.
  always_comb begin
    rot_full_s = {pending_r, pending_r} >> ({1'b0, last_r} + {{CH_W{1'b0}}, 1'b1});
    rot_s      = rot_full_s[NUM_CH-1:0];
    off_s      = {(CH_W+1){1'b0}};
    found_s    = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      off_s   = rot_s[k] ? (CH_W+1)'(k) : off_s;
      found_s = found_s | rot_s[k];
    end
    sum_s    = {1'b0, last_r} + {{CH_W{1'b0}}, 1'b1} + off_s;
    winner_s = (sum_s >= (CH_W+1)'(NUM_CH)) ? CH_W'(sum_s - (CH_W+1)'(NUM_CH)) : CH_W'(sum_s);
  end
`endif

  // Period registers, second counters, pending and sticky overrun flags.
  always_ff @(posedge clk_50m) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i]    <= {PERIOD_W{1'b0}};
        period_r[i] <= {{(PERIOD_W-1){1'b0}}, 1'b1};
      end
      pending_r <= {NUM_CH{1'b0}};
      overrun_r <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_hit_s[i]) begin
          period_r[i] <= period_data;
          cnt_r[i]    <= {PERIOD_W{1'b0}};
        end else if (pps) begin
          if (!ch_enable[i] || fire_s[i]) begin
            cnt_r[i] <= {PERIOD_W{1'b0}};
          end else begin
            cnt_r[i] <= cnt_r[i] + {{(PERIOD_W-1){1'b0}}, 1'b1};
          end
        end
      end
      // A same-cycle fire keeps the flag set even when the channel is being acked.
      pending_r <= fire_s | (pending_r & ~ack_vec_s);
      overrun_r <= overrun_set_s | (overrun_clr ? {NUM_CH{1'b0}} : overrun_r);
    end
  end

  // Arbiter FSM with registered request and channel id.
  always_ff @(posedge clk_50m) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      task_req_r <= 1'b0;
      task_id_r  <= {CH_W{1'b0}};
`ifndef PPS_SCHED_FIXED_PRIO_EN
      last_r     <= CH_W'(NUM_CH - 1);
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            task_id_r  <= winner_s;
`ifndef PPS_SCHED_FIXED_PRIO_EN
            last_r     <= winner_s;
`endif
            task_req_r <= 1'b1;
            state_r    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (task_ack) begin
            task_req_r <= 1'b0;
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          task_req_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign task_req = task_req_r;
  assign task_id  = task_id_r;
  assign pending  = pending_r;
  assign overrun  = overrun_r;

endmodule

// File: tb/tb_pps_task_scheduler.sv
// Scoreboard bench for pps_task_scheduler: stimulus queues expected grants (id and edge), a monitor checks each grant.
module tb_pps_task_scheduler;
  localparam int NUM_CH   = 4;
  localparam int CH_W     = 2;
  localparam int PERIOD_W = 16;

  logic                clk_50m     = 1'b0;
  logic                reset_n     = 1'b0;
  logic                pps         = 1'b0;
  logic [NUM_CH-1:0]   ch_enable   = 4'b0000;
  logic                period_wr   = 1'b0;
  logic [CH_W-1:0]     period_ch   = 2'd0;
  logic [PERIOD_W-1:0] period_data = 16'd0;
  logic                task_req;
  logic [CH_W-1:0]     task_id;
  logic                task_ack    = 1'b0;
  logic [NUM_CH-1:0]   pending;
  logic [NUM_CH-1:0]   overrun;
  logic                overrun_clr = 1'b0;

  typedef struct {
    int id;
    int edge_no;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic auto_ack = 1'b0;

  pps_task_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .PERIOD_W(PERIOD_W)) dut (
    .clk_50m     (clk_50m),
    .reset_n     (reset_n),
    .pps         (pps),
    .ch_enable   (ch_enable),
    .period_wr   (period_wr),
    .period_ch   (period_ch),
    .period_data (period_data),
    .task_req    (task_req),
    .task_id     (task_id),
    .task_ack    (task_ack),
    .pending     (pending),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
  endtask

  // One clock: optional auto-ack of a visible request, then strobes drop at the next negedge.
  task automatic cyc();
    if (auto_ack && task_req) task_ack = 1'b1;
    @(negedge clk_50m);
    pps         = 1'b0;
    period_wr   = 1'b0;
    overrun_clr = 1'b0;
    task_ack    = 1'b0;
  endtask

  task automatic expect_grant(input int id, input int dly);
    exp_q.push_back('{id, edge_cnt + dly});
  endtask

  task automatic wait_req();
    int n = 0;
    while (!task_req && n < 50) begin
      cyc();
      n++;
    end
    chk("req_within_budget", int'(task_req), 1);
  endtask

  task automatic write_period(input int ch, input int data);
    period_wr   = 1'b1;
    period_ch   = CH_W'(ch);
    period_data = PERIOD_W'(data);
    cyc();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    ch_enable = 4'b0000;
    auto_ack  = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  // Monitor: every rising task_req pops one expected grant; the id must hold while requesting.
  initial begin
    logic            prev;
    logic [CH_W-1:0] held;
    exp_t            e;
    prev = 1'b0;
    held = 2'd0;
    forever begin
      @(negedge clk_50m);
      if (task_req && !prev) begin
        chk("grant_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("grant_id", int'(task_id), e.id);
          chk("grant_edge", edge_cnt, e.edge_no);
        end
        held = task_id;
      end else if (task_req && prev) begin
        chk("id_stable", int'(task_id), int'(held));
      end
      prev = task_req;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    cyc();
    chk("rst_task_req", int'(task_req), 0);
    chk("rst_task_id", int'(task_id), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset_n = 1'b1;

    // Period 3 on ch0: grants on pps 3, 6, 9, two edges after the pps.
    write_period(0, 3);
    ch_enable = 4'b0001;
    auto_ack  = 1'b1;
    for (int p = 1; p <= 9; p++) begin
      pps = 1'b1;
      if (p % 3 == 0) expect_grant(0, 2);
      repeat (6) cyc();
    end
    chk("t1_overrun", int'(overrun), 0);
    chk("t1_pending", int'(pending), 0);
    chk("t1_drained", exp_q.size(), 0);

    // All channels fire together; 10-cycle stall on the first grant, then one ack per grant.
    do_reset();
    ch_enable = 4'b1111;
    pps = 1'b1;
    expect_grant(0, 2);
    cyc();
    wait_req();
    repeat (10) cyc();
    for (int i = 1; i <= 4; i++) begin
`ifdef PPS_SCHED_FIXED_PRIO_EN
      if (i < 4) begin
        pps = 1'b1;
        expect_grant(0, 2);
      end
`else
      if (i < 4) expect_grant(i, 2);
`endif
      task_ack = 1'b1;
      cyc();
      if (i < 4) wait_req();
    end
`ifndef PPS_SCHED_FIXED_PRIO_EN
    chk("t2_pending", int'(pending), 0);
`endif
    chk("t2_drained", exp_q.size(), 0);

    // Unacked ch2: overrun after the 2nd pps; a set beats a simultaneous clear.
    do_reset();
    ch_enable = 4'b0100;
    pps = 1'b1;
    expect_grant(2, 2);
    cyc();
    repeat (3) cyc();
    chk("t3_ovr_after_1", int'(overrun), 0);
    pps = 1'b1;
    cyc();
    chk("t3_ovr_after_2", int'(overrun), 4);
    pps = 1'b1;
    overrun_clr = 1'b1;
    cyc();
    chk("t3_ovr_clr_vs_set", int'(overrun), 4);
    repeat (2) cyc();
    overrun_clr = 1'b1;
    cyc();
    chk("t3_ovr_cleared", int'(overrun), 0);
    chk("t3_pending", int'(pending), 4);
    task_ack = 1'b1;
    cyc();
    chk("t3_pending_acked", int'(pending), 0);
    cyc();
    chk("t3_drained", exp_q.size(), 0);

    // Period write coinciding with the 5th pps restarts the count: next fire on the 10th.
    do_reset();
    write_period(1, 5);
    ch_enable = 4'b0010;
    auto_ack  = 1'b1;
    for (int p = 1; p <= 10; p++) begin
      pps = 1'b1;
      if (p == 5) begin
        period_wr   = 1'b1;
        period_ch   = 2'd1;
        period_data = 16'd5;
      end
      if (p == 10) expect_grant(1, 2);
      repeat (4) cyc();
    end
    chk("t4_overrun", int'(overrun), 0);
    chk("t4_drained", exp_q.size(), 0);

    // Period 0 on ch3 fires every pps; ack and fire on the same edge keep pending without overrun.
    do_reset();
    write_period(3, 0);
    ch_enable = 4'b1000;
    pps = 1'b1;
    expect_grant(3, 2);
    cyc();
    cyc();
    chk("t5_req_up", int'(task_req), 1);
    task_ack = 1'b1;
    pps = 1'b1;
    expect_grant(3, 2);
    cyc();
    chk("t5_pending_kept", int'(pending), 8);
    chk("t5_no_overrun", int'(overrun), 0);
    chk("t5_req_gap", int'(task_req), 0);
    cyc();
    task_ack = 1'b1;
    cyc();
    chk("t5_pending_acked", int'(pending), 0);
    chk("t5_overrun_end", int'(overrun), 0);
    cyc();
    chk("t5_drained", exp_q.size(), 0);

    // Reset while requesting drops everything; periods return to 1.
    do_reset();
    write_period(0, 3);
    ch_enable = 4'b0011;
    pps = 1'b1;
    expect_grant(1, 2);
    cyc();
    cyc();
    pps = 1'b1;
    cyc();
    chk("t6_req_before", int'(task_req), 1);
    chk("t6_ovr_before", int'(overrun), 2);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk("t6_req_after", int'(task_req), 0);
    chk("t6_id_after", int'(task_id), 0);
    chk("t6_pending_after", int'(pending), 0);
    chk("t6_overrun_after", int'(overrun), 0);
    ch_enable = 4'b0001;
    auto_ack  = 1'b1;
    pps = 1'b1;
    expect_grant(0, 2);
    repeat (5) cyc();
    chk("t6_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
